// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of mem_port_arbiter.
//
// Handshake: the master raises mem_req together with mem_we, mem_be, mem_addr
// and mem_wdata and holds all of them stable until it samples mem_ack high on
// a rising clock edge. The slave pulses mem_ack for exactly one cycle and
// presents mem_rdata in that same cycle. A mem_ack while mem_req is low has no
// meaning and is ignored by the master.
//
// Signals:
//   mem_req    master -> slave  request, held until mem_ack
//   mem_we     master -> slave  1 = write
//   mem_be     master -> slave  byte enables
//   mem_addr   master -> slave  word-aligned byte address
//   mem_wdata  master -> slave  lane-steered write data
//   mem_rdata  slave -> master  read word, valid with mem_ack
//   mem_ack    slave -> master  one-cycle completion
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the
// load/store path. Data has fixed priority over fetch. Stores get byte
// enables and replicated write lanes; loads get lane extraction and sign or
// zero extension. A per-access timeout aborts a transaction that never sees
// mem_ack.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_valid)
//   if_rdata/if_valid/if_err       fetch result, one-cycle valid pulse
//   d_req/d_we/d_funct3/d_addr/d_wdata  data request (held until d_valid)
//   d_rdata/d_valid/d_err          data result, one-cycle valid pulse
//   mem                            memory bus (master side)
//   stall                          combinational core stall
//   dbg_state                      current FSM state
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_valid,
    output logic               if_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [2:0]         d_funct3,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic [31:0]        d_rdata,
    output logic               d_valid,
    output logic               d_err,
    mem_port_arbiter_if.master mem,
    output logic               stall,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    // Last count value of a transaction; reaching it without ack aborts.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [1:0]  lat_off;
    logic [2:0]  lat_f3;

    logic        d_elig;
    logic        if_elig;
    logic        d_bad;
    logic        if_bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // A request whose valid is high this cycle has just finished and must
    // not be granted again while the requester is still dropping req.
    assign d_elig  = d_req & ~d_valid;
    assign if_elig = if_req & ~if_valid;

    assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
    assign dbg_state = state;

    // funct3[1:0] == 11 covers both 011 and 111.
    assign d_bad = (d_funct3[1:0] == 2'b11)
                 | ((d_funct3[1:0] == 2'b01) & d_addr[0])
                 | ((d_funct3[1:0] == 2'b10) & (d_addr[1:0] != 2'b00));
    assign if_bad = (if_addr[1:0] != 2'b00);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = d_wdata;
        case (d_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (lat_off)
            2'd0: ld_byte = mem.mem_rdata[7:0];
            2'd1: ld_byte = mem.mem_rdata[15:8];
            2'd2: ld_byte = mem.mem_rdata[23:16];
            2'd3: ld_byte = mem.mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = lat_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (lat_f3[1:0])
            2'b00:   ld_val = lat_f3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = lat_f3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            lat_off       <= 2'd0;
            lat_f3        <= 3'd0;
            if_rdata      <= 32'd0;
            if_valid      <= 1'b0;
            if_err        <= 1'b0;
            d_rdata       <= 32'd0;
            d_valid       <= 1'b0;
            d_err         <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'd0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_elig) begin
                        if (d_bad) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end else begin
                            state         <= DATA;
                            cnt           <= 8'd0;
                            lat_off       <= d_addr[1:0];
                            lat_f3        <= d_funct3;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= d_we;
                            mem.mem_be    <= d_we ? st_be : 4'b1111;
                            mem.mem_addr  <= {d_addr[31:2], 2'b00};
                            mem.mem_wdata <= d_we ? st_wdata : 32'd0;
                        end
                    end else if (if_elig) begin
                        if (if_bad) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= 32'd0;
                        end else begin
                            state         <= FETCH;
                            cnt           <= 8'd0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= 1'b0;
                            mem.mem_be    <= 4'b1111;
                            mem.mem_addr  <= {if_addr[31:2], 2'b00};
                            mem.mem_wdata <= 32'd0;
                        end
                    end
                end
                FETCH, DATA: begin
                    // Ack is checked first so a same-cycle ack beats timeout.
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        if (state == FETCH) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem.mem_rdata;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= mem.mem_we ? 32'd0 : ld_val;
                        end
                    end else if (cnt == TO_LAST) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        if (state == FETCH) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= 32'd0;
                        end else begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions, hand-written
// sequences for priority, timeout, reset and stray-ack corners.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        stall;
    logic [1:0]  dbg_state;

    mem_port_arbiter_if mem ();

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_funct3  (d_funct3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem       (mem.master),
        .stall     (stall),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    int          ack_delay;
    logic [31:0] mem_word;
    bit          force_ack;
    int          req_age;
    int          hi_count;
    int          access_count;

    initial begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'd0;
        req_age       = 0;
        hi_count      = 0;
        access_count  = 0;
        forever begin
            tick();
            mem.mem_ack = 1'b0;
            if (mem.mem_req === 1'b1) begin
                if (req_age == 0) access_count++;
                hi_count++;
                if (req_age == ack_delay) begin
                    mem.mem_ack   = 1'b1;
                    mem.mem_rdata = mem_word;
                end
                req_age++;
            end else begin
                req_age = 0;
                if (force_ack) begin
                    mem.mem_ack   = 1'b1;
                    mem.mem_rdata = 32'hFFFF_FFFF;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks;
    int errors;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Pops the expected {err, rdata} for a finished transaction and compares.
    task automatic check_result(input string name, input bit is_fetch, input bit skip_rdata);
        logic [32:0] e;
        e = exp_q.pop_front();
        if (is_fetch) begin
            chk({name, " if_err"}, {31'd0, if_err}, {31'd0, e[32]});
            chk({name, " if_rdata"}, if_rdata, e[31:0]);
        end else begin
            chk({name, " d_err"}, {31'd0, d_err}, {31'd0, e[32]});
            if (!skip_rdata) chk({name, " d_rdata"}, d_rdata, e[31:0]);
        end
    endtask

    // Waits (bounded) for the requester's valid, capturing the first mem beat.
    task automatic wait_valid(input bit is_fetch, input int limit, output bit got,
                              output bit saw_req, output logic [31:0] f_addr,
                              output logic f_we, output logic [3:0] f_be,
                              output logic [31:0] f_wd);
        int n;
        n       = 0;
        got     = 1'b0;
        saw_req = 1'b0;
        f_addr  = 32'd0;
        f_we    = 1'b0;
        f_be    = 4'd0;
        f_wd    = 32'd0;
        while (!got && n < limit) begin
            tick();
            n++;
            if (mem.mem_req && !saw_req) begin
                saw_req = 1'b1;
                f_addr  = mem.mem_addr;
                f_we    = mem.mem_we;
                f_be    = mem.mem_be;
                f_wd    = mem.mem_wdata;
            end
            got = is_fetch ? if_valid : d_valid;
        end
    endtask

    // ---------------- table ----------------
    typedef struct {
        bit          fetch;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          ack_dly;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_acc;
    } vec_t;

    function automatic vec_t mk(bit fetch, bit we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] mrd, int ack_dly,
                                logic [3:0] exp_be, logic [31:0] exp_wd,
                                logic [31:0] exp_rd, bit exp_err, bit exp_acc);
        vec_t v;
        v.fetch = fetch;  v.we = we;          v.f3 = f3;         v.addr = addr;
        v.wdata = wdata;  v.mrd = mrd;        v.ack_dly = ack_dly;
        v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_rd = exp_rd;
        v.exp_err = exp_err; v.exp_acc = exp_acc;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic run_vec(input int idx, input vec_t v);
        bit          got;
        bit          saw;
        logic [31:0] fa;
        logic        fwe;
        logic [3:0]  fbe;
        logic [31:0] fwd;
        int          base;
        int          exp_len;
        string       nm;
        nm = $sformatf("vec%0d", idx);

        ack_delay = v.ack_dly;
        mem_word  = v.mrd;
        base      = hi_count;
        if (v.fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req    = 1'b1;
            d_we     = v.we;
            d_funct3 = v.f3;
            d_addr   = v.addr;
            d_wdata  = v.wdata;
        end
        exp_q.push_back({v.exp_err, v.exp_rd});
        #1;
        chk({nm, " stall_busy"}, {31'd0, stall}, 32'd1);

        wait_valid(v.fetch, 40, got, saw, fa, fwe, fbe, fwd);
        if (!got) begin
            chk({nm, " valid_seen"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check_result(nm, v.fetch, v.we && !v.exp_err);
        end
        chk({nm, " mem_access"}, {31'd0, saw}, {31'd0, v.exp_acc});
        if (v.exp_acc) begin
            chk({nm, " mem_addr"}, fa, {v.addr[31:2], 2'b00});
            chk({nm, " mem_we"}, {31'd0, fwe}, {31'd0, v.we});
            chk({nm, " mem_be"}, {28'd0, fbe}, {28'd0, v.exp_be});
            if (v.we) chk({nm, " mem_wdata"}, fwd, v.exp_wd);
        end
        exp_len = !v.exp_acc ? 0 : (v.ack_dly < 0 ? 16 : v.ack_dly + 1);
        chk({nm, " req_cycles"}, hi_count - base, exp_len);

        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        chk({nm, " valid_once"}, {30'd0, if_valid, d_valid}, 32'd0);
        chk({nm, " stall_idle"}, {31'd0, stall}, 32'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        bit          got;
        bit          saw;
        logic [31:0] fa;
        logic        fwe;
        logic [3:0]  fbe;
        logic [31:0] fwd;
        int          acc_base;

        checks    = 0;
        errors    = 0;
        ack_delay = 1;
        mem_word  = 32'd0;
        force_ack = 1'b0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_funct3  = 3'd0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;

        //          fetch we f3     addr          wdata         mrd           dly  be       wd            rd            err acc
        vecs[0]  = mk(1, 0, 3'b000, 32'h100, 32'h0,         32'h00A00093, 2,  4'b1111, 32'h0,        32'h00A00093, 0, 1);
        vecs[1]  = mk(1, 0, 3'b000, 32'h104, 32'h0,         32'h00000013, 0,  4'b1111, 32'h0,        32'h00000013, 0, 1);
        vecs[2]  = mk(1, 0, 3'b000, 32'h102, 32'h0,         32'h0,        1,  4'b1111, 32'h0,        32'h0,        1, 0);
        vecs[3]  = mk(0, 0, 3'b010, 32'h200, 32'h0,         32'hDEADBEEF, 1,  4'b1111, 32'h0,        32'hDEADBEEF, 0, 1);
        vecs[4]  = mk(0, 1, 3'b000, 32'h203, 32'h123456AB,  32'h0,        1,  4'b1000, 32'hABABABAB, 32'h0,        0, 1);
        vecs[5]  = mk(0, 1, 3'b000, 32'h200, 32'h00000011,  32'h0,        0,  4'b0001, 32'h11111111, 32'h0,        0, 1);
        vecs[6]  = mk(0, 1, 3'b001, 32'h202, 32'h123456AB,  32'h0,        1,  4'b1100, 32'h56AB56AB, 32'h0,        0, 1);
        vecs[7]  = mk(0, 1, 3'b001, 32'h200, 32'h0000BEEF,  32'h0,        1,  4'b0011, 32'hBEEFBEEF, 32'h0,        0, 1);
        vecs[8]  = mk(0, 1, 3'b001, 32'h201, 32'h123456AB,  32'h0,        1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[9]  = mk(0, 1, 3'b010, 32'h204, 32'hCAFEF00D,  32'h0,        1,  4'b1111, 32'hCAFEF00D, 32'h0,        0, 1);
        vecs[10] = mk(0, 1, 3'b010, 32'h206, 32'hCAFEF00D,  32'h0,        1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[11] = mk(0, 0, 3'b000, 32'h300, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'hFFFFFF85, 0, 1);
        vecs[12] = mk(0, 0, 3'b100, 32'h300, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'h00000085, 0, 1);
        vecs[13] = mk(0, 0, 3'b001, 32'h302, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'hFFFF80F0, 0, 1);
        vecs[14] = mk(0, 0, 3'b101, 32'h302, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'h000080F0, 0, 1);
        vecs[15] = mk(0, 0, 3'b000, 32'h301, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'h0000007F, 0, 1);
        vecs[16] = mk(0, 0, 3'b100, 32'h303, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'h00000080, 0, 1);
        vecs[17] = mk(0, 0, 3'b001, 32'h300, 32'h0,         32'h80F07F85, 1,  4'b1111, 32'h0,        32'h00007F85, 0, 1);
        vecs[18] = mk(0, 0, 3'b000, 32'h302, 32'h0,         32'h80F07F85, 3,  4'b1111, 32'h0,        32'hFFFFFFF0, 0, 1);
        vecs[19] = mk(0, 0, 3'b010, 32'h302, 32'h0,         32'h80F07F85, 1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[20] = mk(0, 0, 3'b011, 32'h300, 32'h0,         32'h80F07F85, 1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[21] = mk(0, 0, 3'b111, 32'h300, 32'h0,         32'h80F07F85, 1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[22] = mk(0, 1, 3'b011, 32'h300, 32'h55555555,  32'h0,        1,  4'b0000, 32'h0,        32'h0,        1, 0);
        vecs[23] = mk(0, 0, 3'b010, 32'h300, 32'h0,         32'h80F07F85, -1, 4'b1111, 32'h0,        32'h0,        1, 1);
        vecs[24] = mk(0, 0, 3'b010, 32'h300, 32'h0,         32'h80F07F85, 15, 4'b1111, 32'h0,        32'h80F07F85, 0, 1);

        // Reset state.
        repeat (3) tick();
        chk("rst mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("rst valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst state", {30'd0, dbg_state}, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst mem_be", {28'd0, mem.mem_be}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Simultaneous fetch and data: data first, one access each.
        acc_base  = access_count;
        ack_delay = 0;
        mem_word  = 32'h11223344;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_funct3  = 3'b010;
        d_addr    = 32'h200;
        exp_q.push_back({1'b0, 32'h11223344});
        exp_q.push_back({1'b0, 32'h11223344});
        wait_valid(1'b0, 40, got, saw, fa, fwe, fbe, fwd);
        chk("simul d_valid", {31'd0, got}, 32'd1);
        chk("simul first_addr", fa, 32'h200);
        chk("simul if_valid_low", {31'd0, if_valid}, 32'd0);
        if (got) check_result("simul data", 1'b0, 1'b0);
        else void'(exp_q.pop_front());
        d_req = 1'b0;
        wait_valid(1'b1, 40, got, saw, fa, fwe, fbe, fwd);
        chk("simul if_valid", {31'd0, got}, 32'd1);
        chk("simul second_addr", fa, 32'h100);
        if (got) check_result("simul fetch", 1'b1, 1'b0);
        else void'(exp_q.pop_front());
        if_req = 1'b0;
        tick();
        chk("simul accesses", access_count - acc_base, 32'd2);
        chk("simul stall", {31'd0, stall}, 32'd0);

        // Stray ack while idle is ignored.
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        chk("stray valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("stray state", {30'd0, dbg_state}, 32'd0);
        chk("stray mem_req", {31'd0, mem.mem_req}, 32'd0);

        // Reset in the middle of a data access, then re-issue.
        ack_delay = -1;
        mem_word  = 32'h80F07F85;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_funct3  = 3'b010;
        d_addr    = 32'h300;
        repeat (3) tick();
        chk("mid state_data", {30'd0, dbg_state}, 32'd2);
        chk("mid mem_req", {31'd0, mem.mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("rst_mid state", {30'd0, dbg_state}, 32'd0);
        chk("rst_mid d_valid", {31'd0, d_valid}, 32'd0);
        rst       = 1'b0;
        ack_delay = 1;
        exp_q.push_back({1'b0, 32'h80F07F85});
        wait_valid(1'b0, 40, got, saw, fa, fwe, fbe, fwd);
        chk("reissue d_valid", {31'd0, got}, 32'd1);
        if (got) check_result("reissue", 1'b0, 1'b0);
        else void'(exp_q.pop_front());
        d_req = 1'b0;
        tick();
        chk("reissue end_state", {30'd0, dbg_state}, 32'd0);

        chk("scoreboard empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch and the load/store path of the RISC-V core.
- Serialises fetch and data requests over a req/ack memory interface.
- Generates byte enables and write-lane steering for SB/SH/SW, and extracts and extends LB/LBU/LH/LHU/LW read data.
- Drives the core's stall so the PC and register writeback hold until the access completes.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ack before aborting with error (1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held with if_addr until if_valid
if_addr  input  32  fetch byte address; word aligned
if_rdata  output  32  fetched instruction
if_valid  output  1  one-cycle completion pulse for fetch
if_err  output  1  fetch error (misaligned or timeout); valid with if_valid
d_req  input  1  data request (chip select); held with d_* until d_valid
d_we  input  1  1 = store, 0 = load
d_funct3  input  3  access size/sign, RISC-V load/store encoding
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned
d_rdata  output  32  load result, extended per funct3
d_valid  output  1  one-cycle completion pulse for data
d_err  output  1  data error (misaligned, illegal funct3, timeout); valid with d_valid
mem_req  output  1  memory request; held until mem_ack
mem_we  output  1  memory write
mem_be  output  4  byte enables
mem_addr  output  32  word address: {addr[31:2], 2'b00}
mem_wdata  output  32  lane-steered write data
mem_rdata  input  32  memory read word; sampled on mem_ack
mem_ack  input  1  one-cycle completion from memory
stall  output  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid)

Behaviour:
- Reset: state IDLE; all registered outputs 0; timeout counter 0. Reset mid-transaction drops mem_req at the next edge and produces no valid pulse.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - An eligible request is one whose req is high and whose valid is not asserted this cycle. This prevents re-granting a finished request.
  - Data has fixed priority over fetch.
  - On grant, capture the address, we, be and wdata. Enter FETCH or DATA.
  - mem_req rises on the following cycle.
- Data pre-check, done at grant:
  - funct3=011 or funct3[1:0]=11 is illegal.
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Fetch with if_addr[1:0]!=0 is misaligned.
  - On any error: no memory access. valid+err pulse the next cycle, rdata=0, stay IDLE.
- Byte enables (stores):
  - Byte: be = 4'b0001 << addr[1:0]; wdata = byte replicated in all 4 lanes.
  - Half: be = addr[1] ? 1100 : 0011; wdata = half replicated in both halves.
  - Word: be = 1111.
- Loads and fetches: mem_we=0, mem_be=1111.
- FETCH/DATA states:
  - mem_req and all mem_* outputs are held stable.
  - The counter increments each cycle.
  - On mem_ack: register the result, pulse the matching valid for exactly 1 cycle (the cycle after ack), return to IDLE.
  - Load extraction: select the lane by addr[1:0]. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
  - If the counter reaches TIMEOUT without ack: drop mem_req, pulse valid+err, rdata=0, return to IDLE.
  - If mem_ack and timeout occur in the same cycle, ack wins with no error.
- Back-to-back timing:
  - Minimum transaction is 3 cycles from req to valid: grant, mem_req with ack, valid.
  - A new grant is possible in the cycle after valid.
- mem_ack seen in IDLE is ignored.
- Each requester changes its inputs only after its valid; behaviour is undefined otherwise.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, ack 2 cycles after mem_req with rdata=0x00A00093 -> mem_addr=0x100, mem_we=0, be=1111; if_valid pulses once, if_rdata=0x00A00093, stall low the cycle after.
- Simultaneous: if_req and d_req (LW, 0x200) both rise in the same cycle -> data granted first, d_valid pulses, then fetch is granted the next cycle; no duplicate data access.
- Stores: SB with addr=0x203 and wdata=0x1234_56AB -> be=1000, mem_wdata=0xABABABAB; SH with addr=0x202 -> be=1100; SH with addr=0x201 -> no mem_req, d_err=1 with d_valid.
- Loads: mem_rdata=0x80F0_7F85 at addr 0x300. LB with offset 0 -> 0xFFFFFF85; LBU with offset 0 -> 0x00000085; LH with offset 2 -> 0xFFFF80F0; LHU with offset 2 -> 0x000080F0.
- Timeout: TIMEOUT=16, mem_ack never arrives -> mem_req high for exactly 16 cycles, then d_valid=d_err=1, d_rdata=0. Repeat with ack on the 16th cycle -> no error.
- Reset: assert rst while in DATA -> mem_req=0 and state IDLE next cycle, no d_valid; a re-issued request then completes normally.
